prog_loader: RTL and testbench

//  Serial boot loader: writer side of program RAM. Receives 8N1 UART frames, assembles 16-bit words
//  and writes them into p_ram through its address/data/wren port; the core only ever reads that port.

---
 rtl/xm23_loader_pkg.sv | 22 ++
 rtl/prog_loader_uart_rx.sv | 104 ++++++++++
 rtl/prog_loader.sv | 189 ++++++++++++++++++
 tb/tb_prog_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xm23_loader_pkg.sv
// Shared types and helpers for the serial program loader.
package xm23_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        LEN_H,
        LEN_L,
        DATA_H,
        DATA_L,
        CHK,
        RUN
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, byte/valid or framing-error pulse.
module uart_rx
    import xm23_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       ferr_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state_q;
    logic             meta_q;
    logic             sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             valid_q;
    logic             ferr_q;

    // prev_q is one stage behind sync_q so the idle state can see a falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= 3'd0;
                    if (prev_q && !sync_q) state_q <= RX_START;
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        state_q <= sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (sync_q) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_o  = byte_q;
    assign valid_o = valid_q;
    assign ferr_o  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Serial boot loader writing program RAM and holding the core until a GO frame.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
    import xm23_loader_pkg::*;
#(
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         BAUD      = 115200,
    parameter int         ADDR_W    = 15,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_i,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    logic [7:0]  rx_byte_s;
    logic        rx_valid_s;
    logic        rx_ferr_s;
    logic [15:0] frame_word_s;

    loader_state_t     state_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [15:0]       words_left_q;
    logic [7:0]        hold_byte_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [15:0]       mem_data_q;
    logic              mem_wren_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_error_q;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx_i    (rx_i),
        .byte_o  (rx_byte_s),
        .valid_o (rx_valid_s),
        .ferr_o  (rx_ferr_s)
    );

    // High byte of every big-endian pair is parked in hold_byte_q until the low byte lands
    assign frame_word_s = {hold_byte_q, rx_byte_s};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_acc_q;
    logic       go_q;

    // XOR of every byte from ADDR_H through the last data byte, restarted by SYNC
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_acc_q <= 8'h00;
        end else if (rx_valid_s) begin
            if ((state_q == IDLE || state_q == RUN) && rx_byte_s == SYNC_BYTE) begin
                chk_acc_q <= 8'h00;
            end else if (state_q inside {ADDR_H, ADDR_L, LEN_H, LEN_L, DATA_H, DATA_L}) begin
                chk_acc_q <= chk_acc_q ^ rx_byte_s;
            end else begin
                chk_acc_q <= chk_acc_q;
            end
        end
    end
`endif

    // Frame FSM with registered RAM write port and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            word_addr_q   <= '0;
            words_left_q  <= 16'h0000;
            hold_byte_q   <= 8'h00;
            mem_address_q <= '0;
            mem_data_q    <= 16'h0000;
            mem_wren_q    <= 1'b0;
            cpu_hold_q    <= 1'b1;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            go_q          <= 1'b0;
`endif
        end else begin
            mem_wren_q  <= 1'b0;
            load_done_q <= 1'b0;
            if (rx_ferr_s && state_q != IDLE && state_q != RUN) begin
                load_error_q <= 1'b1;
                state_q      <= IDLE;
            end else if (rx_valid_s) begin
                case (state_q)
                    IDLE: begin
                        if (rx_byte_s == SYNC_BYTE) begin
                            load_error_q <= 1'b0;
                            state_q      <= ADDR_H;
                        end
                    end
                    RUN: begin
                        if (rx_byte_s == SYNC_BYTE) begin
                            cpu_hold_q   <= 1'b1;
                            load_error_q <= 1'b0;
                            state_q      <= ADDR_H;
                        end
                    end
                    ADDR_H: begin
                        hold_byte_q <= rx_byte_s;
                        state_q     <= ADDR_L;
                    end
                    ADDR_L: begin
                        word_addr_q <= ADDR_W'(frame_word_s >> 1);
                        state_q     <= LEN_H;
                    end
                    LEN_H: begin
                        hold_byte_q <= rx_byte_s;
                        state_q     <= LEN_L;
                    end
                    LEN_L: begin
                        words_left_q <= frame_word_s;
                        if (frame_word_s == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                            go_q    <= 1'b1;
                            state_q <= CHK;
`else
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                            state_q     <= RUN;
`endif
                        end else begin
                            state_q <= DATA_H;
                        end
                    end
                    DATA_H: begin
                        hold_byte_q <= rx_byte_s;
                        state_q     <= DATA_L;
                    end
                    DATA_L: begin
                        mem_address_q <= word_addr_q;
                        mem_data_q    <= frame_word_s;
                        mem_wren_q    <= 1'b1;
                        word_addr_q   <= word_addr_q + ADDR_W'(1);
                        words_left_q  <= words_left_q - 16'h0001;
                        if (words_left_q == 16'h0001) begin
`ifdef LOADER_CHECKSUM_EN
                            go_q    <= 1'b0;
                            state_q <= CHK;
`else
                            load_done_q <= 1'b1;
                            state_q     <= IDLE;
`endif
                        end else begin
                            state_q <= DATA_H;
                        end
                    end
                    CHK: begin
`ifdef LOADER_CHECKSUM_EN
                        if (rx_byte_s == chk_acc_q) begin
                            load_done_q <= 1'b1;
                            if (go_q) begin
                                cpu_hold_q <= 1'b0;
                                state_q    <= RUN;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            load_error_q <= 1'b1;
                            state_q      <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign cpu_hold    = cpu_hold_q;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_prog_loader;
    import xm23_loader_pkg::*;

    localparam int TB_CLK_HZ = 1600;
    localparam int TB_BAUD   = 100;
    localparam int CPB       = clks_per_bit(TB_CLK_HZ, TB_BAUD);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [14:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int total = 0;
    int bad = 0;

    logic [31:0] wr_seen_q[$];
    int          done_seen = 0;
    int          wr_base;
    int          done_base;

    logic [7:0]  fr_q[$];
    logic [15:0] dq[$];
    logic [31:0] exp_wr_q[$];

    prog_loader #(
        .CLK_HZ    (TB_CLK_HZ),
        .BAUD      (TB_BAUD),
        .ADDR_W    (15),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wren === 1'b1) wr_seen_q.push_back({1'b0, mem_address, mem_data});
        if (load_done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
    endtask

    // Frame model: bytes on the wire and the word writes they must cause
    task automatic build_frame(input logic [15:0] addr, input bit bad_chk);
        logic [7:0]  x;
        logic [15:0] n;
        n = 16'(dq.size());
        fr_q.delete();
        exp_wr_q.delete();
        fr_q.push_back(8'hA5);
        fr_q.push_back(addr[15:8]);
        fr_q.push_back(addr[7:0]);
        fr_q.push_back(n[15:8]);
        fr_q.push_back(n[7:0]);
        foreach (dq[k]) begin
            fr_q.push_back(dq[k][15:8]);
            fr_q.push_back(dq[k][7:0]);
            exp_wr_q.push_back(32'((((int'(addr) / 2) + k) % 32768) * 65536 + int'(dq[k])));
        end
        x = 8'h00;
        for (int i = 1; i < fr_q.size(); i++) x = x ^ fr_q[i];
`ifdef LOADER_CHECKSUM_EN
        fr_q.push_back(x ^ (bad_chk ? 8'h01 : 8'h00));
`endif
    endtask

    task automatic mark();
        wr_base   = wr_seen_q.size();
        done_base = done_seen;
    endtask

    task automatic send_from(input int first);
        for (int i = first; i < fr_q.size(); i++) send_byte(fr_q[i], 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int exp_done, input logic exp_hold, input logic exp_err);
        check({tag, "_nwr"}, 32'(wr_seen_q.size() - wr_base), 32'(exp_wr_q.size()));
        for (int k = 0; k < exp_wr_q.size(); k++)
            if (wr_base + k < wr_seen_q.size()) check({tag, "_wr"}, wr_seen_q[wr_base + k], exp_wr_q[k]);
        check({tag, "_done"}, 32'(done_seen - done_base), 32'(exp_done));
        check({tag, "_hold"}, {31'h0, cpu_hold}, {31'h0, exp_hold});
        check({tag, "_err"}, {31'h0, load_error}, {31'h0, exp_err});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, {17'h0, mem_address}, 32'h0);
        check({tag, "_data"}, {16'h0, mem_data}, 32'h0);
        check({tag, "_wren"}, {31'h0, mem_wren}, 32'h0);
        check({tag, "_hold"}, {31'h0, cpu_hold}, 32'h1);
        check({tag, "_done"}, {31'h0, load_done}, 32'h0);
        check({tag, "_err"}, {31'h0, load_error}, 32'h0);
    endtask

    initial begin
        logic [15:0] ra;
        int          n;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_in");
        reset = 1'b0;
        repeat (CPB) @(negedge clk);
        check_reset_outputs("rst_out");

        // Case 1: two words at byte address 0x0010
        dq.delete();
        dq.push_back(16'h1234);
        dq.push_back(16'hABCD);
        build_frame(16'h0010, 1'b0);
        mark();
        send_from(0);
        check_frame("c1", 1, 1'b1, 1'b0);

        // Case 2: GO frame releases the core, next SYNC holds it again
        dq.delete();
        build_frame(16'h0000, 1'b0);
        mark();
        send_from(0);
        check_frame("c2_go", 1, 1'b0, 1'b0);
        dq.push_back(16'h1234);
        dq.push_back(16'hABCD);
        build_frame(16'h0010, 1'b0);
        mark();
        send_byte(fr_q[0], 1'b0);
        repeat (2) @(negedge clk);
        check("c2_resync_hold", {31'h0, cpu_hold}, 32'h1);
        send_from(1);
        check_frame("c2_reload", 1, 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Case 3: bad checksum keeps the writes but flags an error
        build_frame(16'h0010, 1'b1);
        mark();
        send_from(0);
        check_frame("c3_badchk", 0, 1'b1, 1'b1);
        mark();
        send_byte(8'hA5, 1'b0);
        repeat (2) @(negedge clk);
        check("c3_sync_clr", {31'h0, load_error}, 32'h0);
        rx = 1'b1;
        repeat (CPB * 4) @(negedge clk);
        dq.delete();
        dq.push_back(16'h5A5A);
        build_frame(16'h0100, 1'b0);
        send_from(1);
        check_frame("c3_after", 1, 1'b1, 1'b0);
`endif

        // Case 4: word address wraps from 0x7FFF to 0x0000
        dq.delete();
        dq.push_back(16'($urandom));
        dq.push_back(16'($urandom));
        build_frame(16'hFFFE, 1'b0);
        mark();
        send_from(0);
        check_frame("c4_wrap", 1, 1'b1, 1'b0);
        if (wr_seen_q.size() >= wr_base + 2) begin
            check("c4_w0_addr", {17'h0, wr_seen_q[wr_base][30:16]}, 32'h7FFF);
            check("c4_w1_addr", {17'h0, wr_seen_q[wr_base + 1][30:16]}, 32'h0000);
        end

        // Case 5: framing error on LEN_H, then a good frame straight after
        mark();
        exp_wr_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check_frame("c5_ferr", 0, 1'b1, 1'b1);
        dq.delete();
        dq.push_back(16'($urandom));
        dq.push_back(16'($urandom));
        build_frame(16'h0040, 1'b0);
        mark();
        send_from(0);
        check_frame("c5_good", 1, 1'b1, 1'b0);

        // Random frames: random address, 0..3 words (0 words = GO)
        for (int f = 0; f < 8; f++) begin
            dq.delete();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) dq.push_back(16'($urandom));
            ra = 16'($urandom);
            build_frame(ra, 1'b0);
            mark();
            send_from(0);
            check_frame("rnd", 1, (n == 0) ? 1'b0 : 1'b1, 1'b0);
        end

        // Case 6: reset in the middle of a DATA_H byte, then stray bytes
        dq.delete();
        dq.push_back(16'h1234);
        dq.push_back(16'hABCD);
        build_frame(16'h0010, 1'b0);
        mark();
        exp_wr_q.delete();
        for (int i = 0; i < 5; i++) send_byte(fr_q[i], 1'b0);
        rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("c6_in_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (CPB) @(negedge clk);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        check("c6_nwr", 32'(wr_seen_q.size() - wr_base), 32'h0);
        check("c6_ndone", 32'(done_seen - done_base), 32'h0);
        check_reset_outputs("c6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
